float_enc_pipe: RTL and testbench

FLOAT_ENC_PIPE -- requirements
Module: float_enc_pipe

---
 rtl/float_pkg.sv | 24 ++
 rtl/float_enc_core.sv | 42 ++++
 rtl/float_enc_pipe.sv | 104 ++++++++++
 tb/tb_float_enc_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared widths, input-format encodings and a constant clog2 for the
// float encoder pipeline.
package float_pkg;

    localparam int DEF_IN_W   = 16;
    localparam int DEF_MANT_W = 6;
    localparam int DEF_TAG_W  = 3;

    typedef enum logic {
        FMT_TWOS = 1'b0,
        FMT_SMAG = 1'b1
    } fmt_e;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/float_enc_core.sv
// Combinational encoder: priority-encodes the magnitude into an exponent and
// normalises it into a mantissa whose MSB is the leading one.
module float_enc_core
    import float_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int MANT_W = DEF_MANT_W,
    localparam int EXP_W = clog2(IN_W),
    localparam int OUT_W = 1 + EXP_W + MANT_W
) (
    input  logic              i_sign,
    input  logic [IN_W-2:0]   i_mag,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_zero
);

    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;

    assign o_zero = (i_mag == '0);

    // Exponent is one past the index of the highest set bit (0 for zero)
    always_comb begin
        w_exp = '0;
        for (int i = 0; i < IN_W - 1; i++) begin
            if (i_mag[i]) w_exp = EXP_W'(i + 1);
        end
    end

    // Zero gets a fixed half-scale mantissa; otherwise shift the leading one
    // into the mantissa MSB and drop the bits below
    always_comb begin
        if (o_zero) begin
            w_mant = {1'b1, {(MANT_W-1){1'b0}}};
        end else begin
            w_mant = MANT_W'({i_mag, {MANT_W{1'b0}}} >> w_exp);
        end
    end

    assign o_data = {i_sign, w_exp, w_mant};

endmodule

// File: rtl/float_enc_pipe.sv
// Two-stage valid/ready pipeline converting two's-complement or
// sign-magnitude samples into {sign, EXP, MANT} with a carried channel tag.
module float_enc_pipe
    import float_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int MANT_W = DEF_MANT_W,
    parameter int TAG_W  = DEF_TAG_W,
    localparam int EXP_W = clog2(IN_W),
    localparam int OUT_W = 1 + EXP_W + MANT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_fmt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero
);

    // Magnitude below the sign bit; a two's-complement negative wraps so
    // that the most negative code yields zero
    function automatic logic [IN_W-2:0] mag_of(input logic [IN_W-1:0] d,
                                               input logic            fmt);
        if (fmt_e'(fmt) == FMT_TWOS && d[IN_W-1])
            return $unsigned(-$signed(d[IN_W-2:0]));
        return d[IN_W-2:0];
    endfunction

    logic              r_vld_p1;
    logic              r_sign_p1;
    logic [IN_W-2:0]   r_mag_p1;
    logic [TAG_W-1:0]  r_tag_p1;

    logic              r_vld_p2;
    logic [OUT_W-1:0]  r_data_p2;
    logic [TAG_W-1:0]  r_tag_p2;
    logic              r_zero_p2;

    logic              w_s2_load;
    logic              w_in_xfer;
    logic [OUT_W-1:0]  w_enc_data;
    logic              w_enc_zero;

    assign w_s2_load = r_vld_p1 & (~r_vld_p2 | out_ready);
    assign in_ready  = ~r_vld_p1 | w_s2_load;
    assign w_in_xfer = in_valid & in_ready;

    // ---- stage p1: sign / magnitude / tag ----
    // S1 occupancy: fill on accept, empty when S2 takes the sample
    always_ff @(posedge clk) begin
        if (reset)          r_vld_p1 <= 1'b0;
        else if (w_in_xfer) r_vld_p1 <= 1'b1;
        else if (w_s2_load) r_vld_p1 <= 1'b0;
    end

    // S1 payload captured only on an input transfer
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_sign_p1 <= in_data[IN_W-1];
            r_mag_p1  <= mag_of(in_data, in_fmt);
            r_tag_p1  <= in_tag;
        end
    end

    float_enc_core #(
        .IN_W   (IN_W),
        .MANT_W (MANT_W)
    ) u_core (
        .i_sign (r_sign_p1),
        .i_mag  (r_mag_p1),
        .o_data (w_enc_data),
        .o_zero (w_enc_zero)
    );

    // ---- stage p2: encoded output ----
    // Output register: load when S1 advances, hold under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_tag_p2  <= '0;
            r_zero_p2 <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2  <= 1'b1;
            r_data_p2 <= w_enc_data;
            r_tag_p2  <= r_tag_p1;
            r_zero_p2 <= w_enc_zero;
        end else if (out_ready) begin
            r_vld_p2  <= 1'b0;
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_tag   = r_tag_p2;
    assign out_zero  = r_zero_p2;

endmodule

// File: tb/tb_float_enc_pipe.sv
// Self-checking bench for float_enc_pipe at default parameters.
module tb_float_enc_pipe;

    localparam int IN_W   = 16;
    localparam int MANT_W = 6;
    localparam int TAG_W  = 3;
    localparam int EXP_W  = 4;
    localparam int OUT_W  = 1 + EXP_W + MANT_W;
    localparam int N_STREAM = 19880;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_fmt;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;

    int tests_run;
    int tests_failed;

    logic [OUT_W-1:0] q_data[$];
    logic [TAG_W-1:0] q_tag[$];
    logic             q_zero[$];

    float_enc_pipe #(
        .IN_W   (IN_W),
        .MANT_W (MANT_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_fmt    (in_fmt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding computed with plain integer arithmetic
    function automatic logic [OUT_W-1:0] ref_enc(input logic [IN_W-1:0] d,
                                                 input logic fmt,
                                                 output logic z);
        longint mag;
        longint m;
        int     e;
        logic   s;
        s = d[IN_W-1];
        if (fmt == 1'b0 && s)
            mag = ((longint'(1) << IN_W) - longint'(d)) % (longint'(1) << (IN_W-1));
        else
            mag = longint'(d) % (longint'(1) << (IN_W-1));
        z = (mag == 0);
        e = 0;
        while ((longint'(1) << e) <= mag) e++;
        if (mag == 0) m = longint'(1) << (MANT_W-1);
        else          m = ((mag << MANT_W) >> e) % (longint'(1) << MANT_W);
        return {s, EXP_W'(e), MANT_W'(m)};
    endfunction

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_fmt = 1'b0;
        in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        tests_run++;
        if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data got=%h want=000", out_data); end
        tests_run++;
        if (out_tag !== '0) begin tests_failed++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        tests_run++;
        if (out_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_vectors;
        logic [IN_W-1:0]  vd [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF,
                                     16'h1234, 16'h8000, 16'h8000, 16'h8001};
        logic             vf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [OUT_W-1:0] ve [8] = '{11'h020, 11'h060, 11'h460, 11'h3FF,
                                     11'h364, 11'h420, 11'h420, 11'h460};
        logic             vz [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [TAG_W-1:0] t;
        for (int i = 0; i < 8; i++) begin
            t = TAG_W'(7 - i);
            in_valid = 1'b1; in_data = vd[i]; in_fmt = vf[i]; in_tag = t;
            out_ready = 1'b1;
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_in_ready got=%b want=1", i, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL vec%0d_latency1 out_valid got=%b want=0", i, out_valid); end
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_latency2 out_valid got=%b want=1", i, out_valid); end
            tests_run++;
            if (out_data !== ve[i]) begin tests_failed++; $display("FAIL vec%0d_data in=%h fmt=%b got=%h want=%h", i, vd[i], vf[i], out_data, ve[i]); end
            tests_run++;
            if (out_zero !== vz[i]) begin tests_failed++; $display("FAIL vec%0d_zero got=%b want=%b", i, out_zero, vz[i]); end
            tests_run++;
            if (out_tag !== t) begin tests_failed++; $display("FAIL vec%0d_tag got=%h want=%h", i, out_tag, t); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [IN_W-1:0]  d [4];
        logic             f [4];
        logic [OUT_W-1:0] e [4];
        logic             z [4];
        logic [OUT_W-1:0] snap;
        int sent;
        int got;
        sent = 0; got = 0; snap = '0;
        for (int i = 0; i < 4; i++) begin
            d[i] = IN_W'($urandom);
            f[i] = 1'($urandom_range(0, 1));
            e[i] = ref_enc(d[i], f[i], z[i]);
        end
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 4);
            in_data   = d[sent % 4];
            in_fmt    = f[sent % 4];
            in_tag    = TAG_W'(sent);
            #1;
            if (cyc == 2) begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_full got=%b want=0", in_ready); end
                tests_run++;
                if (sent != 2) begin tests_failed++; $display("FAIL bp_accepted got=%0d want=2", sent); end
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== e[0]) begin
                    tests_failed++; $display("FAIL bp_head vld=%b data=%h want vld=1 data=%h", out_valid, out_data, e[0]);
                end
                snap = out_data;
            end
            if (cyc == 3) begin
                tests_run++;
                if (out_data !== snap) begin tests_failed++; $display("FAIL bp_stable got=%h want=%h", out_data, snap); end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_data !== e[got] || out_tag !== TAG_W'(got) || out_zero !== z[got]) begin
                    tests_failed++;
                    $display("FAIL bp_out%0d data=%h tag=%h zero=%b want data=%h tag=%h zero=%b",
                             got, out_data, out_tag, out_zero, e[got], TAG_W'(got), z[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != 4) begin tests_failed++; $display("FAIL bp_count got=%0d want=4", got); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_stream;
        int sent;
        int got;
        logic [IN_W-1:0] d;
        logic f;
        logic z;
        logic [OUT_W-1:0] e;
        sent = 0; got = 0;
        q_data.delete(); q_tag.delete(); q_zero.delete();
        for (int cyc = 0; cyc < N_STREAM + 10 && got < N_STREAM; cyc++) begin
            d = IN_W'($urandom);
            f = 1'($urandom_range(0, 1));
            in_valid  = (sent < N_STREAM);
            in_data   = d;
            in_fmt    = f;
            in_tag    = TAG_W'($urandom);
            out_ready = 1'b1;
            #1;
            if (sent < N_STREAM) begin
                tests_run++;
                if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
            end
            if (cyc >= 2) begin
                tests_run++;
                if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_rate cyc=%0d out_valid got=%b want=1", cyc, out_valid); end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (q_data.size() == 0) begin
                    tests_failed++; $display("FAIL stream_extra cyc=%0d got=%h want=none", cyc, out_data);
                end else begin
                    if (out_data !== q_data[0] || out_tag !== q_tag[0] || out_zero !== q_zero[0]) begin
                        tests_failed++;
                        $display("FAIL stream_out%0d data=%h tag=%h zero=%b want data=%h tag=%h zero=%b",
                                 got, out_data, out_tag, out_zero, q_data[0], q_tag[0], q_zero[0]);
                    end
                    void'(q_data.pop_front()); void'(q_tag.pop_front()); void'(q_zero.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                e = ref_enc(d, f, z);
                q_data.push_back(e); q_tag.push_back(in_tag); q_zero.push_back(z);
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != N_STREAM) begin tests_failed++; $display("FAIL stream_count got=%0d want=%0d", got, N_STREAM); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream;
        in_valid = 1'b1; in_data = 16'h0123; in_fmt = 1'b0; in_tag = 3'd5;
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rst_full out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        reset = 1'b1; out_ready = 1'b1; in_data = 16'h0456;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
        tests_run++;
        if (out_data !== '0) begin tests_failed++; $display("FAIL rst_mid_out_data got=%h want=000", out_data); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_stale cyc=%0d out_valid got=%b want=0", i, out_valid); end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
